// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bus between register-read and writeback
interface alu_seq_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Res;
    logic             Zflag;
    logic             Nflag;
    logic             Cflag;
    logic             Vflag;
    logic             busy;
    modport master (
        output in_valid, A, B, op, out_ready,
        input  in_ready, out_valid, Res, Zflag, Nflag, Cflag, Vflag, busy
    );
    modport slave (
        input  in_valid, A, B, op, out_ready,
        output in_ready, out_valid, Res, Zflag, Nflag, Cflag, Vflag, busy
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with Z/N/C/V flags and iterative shift-add multiply
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input logic       CLK,
    input logic       RST_N,
    alu_seq_if.slave  bus
);
    localparam int M = WIDTH - 1;
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hi_nz, r_z, r_n, r_c, r_v;
    logic             w_accept, w_is_mul, w_last, w_hi;
    logic [WIDTH:0]   w_sum, w_add;
    logic [WIDTH-1:0] w_diff, w_res;
    logic             w_ltu, w_lts, w_c, w_v;

    assign w_accept = bus.in_valid & (r_state == IDLE);
    assign w_is_mul = bus.op == 3'b100;
    assign w_last   = r_cnt == CNT_W'(M);
    assign w_sum    = {1'b0, bus.A} + {1'b0, bus.B};
    assign w_diff   = bus.A - bus.B;
    assign w_ltu    = bus.A < bus.B;
    assign w_lts    = $signed(bus.A) < $signed(bus.B);
    assign w_add    = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_hi     = r_hi_nz | w_add[WIDTH] | (r_mcand[M] & (|r_mplier[M:1]));

    assign bus.in_ready  = r_state == IDLE;
    assign bus.out_valid = r_state == DONE;
    assign bus.busy      = r_state == MUL;
    assign bus.Res       = r_res;
    assign bus.Zflag     = r_z;
    assign bus.Nflag     = r_n;
    assign bus.Cflag     = r_c;
    assign bus.Vflag     = r_v;

    // state register; reset abandons any multiply in flight
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: accept only in IDLE, leave MUL after WIDTH steps, leave DONE on handshake
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_is_mul ? MUL : DONE) : IDLE;
            MUL:     w_next = w_last ? DONE : MUL;
            DONE:    w_next = bus.out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // single-cycle result and carry/overflow for every op except multiply
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (bus.op)
            3'b000: begin
                w_res = w_sum[M:0];
                w_c   = w_sum[WIDTH];
                w_v   = (bus.A[M] == bus.B[M]) & (w_sum[M] != bus.A[M]);
            end
            3'b001: w_res = bus.A & bus.B;
            3'b010: w_res = bus.A | bus.B;
            3'b011: begin
                w_res = w_diff;
                w_c   = w_ltu;
                w_v   = (bus.A[M] != bus.B[M]) & (w_diff[M] != bus.A[M]);
            end
            3'b101: w_res = bus.A ^ bus.B;
            3'b110: w_res = {{M{1'b0}}, w_ltu};
            3'b111: w_res = {{M{1'b0}}, w_lts};
            default: w_res = '0;
        endcase
    end

    // operand capture, shift-add iterations and registered result/flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi_nz  <= 1'b0;
            r_res    <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= bus.A;
            r_mplier <= bus.B;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi_nz  <= 1'b0;
            if (!w_is_mul) begin
                r_res <= w_res;
                r_z   <= w_res == '0;
                r_n   <= w_res[M];
                r_c   <= w_c;
                r_v   <= w_v;
            end
        end else if (r_state == MUL) begin
            r_acc    <= w_add[M:0];
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            r_hi_nz  <= w_hi;
            if (w_last) begin
                r_res <= w_add[M:0];
                r_z   <= w_add[M:0] == '0;
                r_n   <= w_add[M];
                r_c   <= w_hi;
                r_v   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq (WIDTH=32)
module tb_alu_seq;
    typedef struct packed {
        logic [31:0] res;
        logic        z, n, c, v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t sb[$];

    alu_seq_if #(.WIDTH(32)) bus ();
    alu_seq #(.WIDTH(32)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o);
        exp_t        e;
        logic [63:0] p;
        longint      s;
        e = '0;
        case (o)
            3'b000: begin
                p = {32'd0, a} + {32'd0, b};
                e.res = p[31:0];
                e.c = p[32];
                s = longint'($signed(a)) + longint'($signed(b));
                e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'b001: e.res = a & b;
            3'b010: e.res = a | b;
            3'b011: begin
                e.res = a - b;
                e.c = a < b;
                s = longint'($signed(a)) - longint'($signed(b));
                e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'b100: begin
                p = {32'd0, a} * {32'd0, b};
                e.res = p[31:0];
                e.c = |p[63:32];
            end
            3'b101: e.res = a ^ b;
            3'b110: e.res = (a < b) ? 32'd1 : 32'd0;
            default: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        e.z = e.res == 32'd0;
        e.n = e.res[31];
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o, input bit keep);
        int i;
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        bus.op = o;
        i = 0;
        while (bus.in_ready !== 1'b1 && i < 200) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i >= 200) check("accept_timeout", 0, 1);
        sb.push_back(model(a, b, o));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("drain", sb.size(), 0);
    endtask

    // scoreboard: compare every result at its handshake
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (sb.size() == 0) check("spurious_out", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_res", bus.Res, e.res);
                check("sb_z", bus.Zflag, e.z);
                check("sb_n", bus.Nflag, e.n);
                check("sb_c", bus.Cflag, e.c);
                check("sb_v", bus.Vflag, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nb, a0, a1, a2, a3, o0;
        bus.in_valid = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.op = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", bus.Res, 0);
        check("rst_flags", {bus.Zflag, bus.Nflag, bus.Cflag, bus.Vflag}, 0);
        check("rst_ovalid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_iready", bus.in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'd7, 32'd9, 3'b100, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("mr_res", bus.Res, 0);
        check("mr_ovalid", bus.out_valid, 0);
        check("mr_busy", bus.busy, 0);
        check("mr_idle", bus.in_ready, 1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'd2, 32'd3, 3'b000, 0);
        check("add_lat", bus.out_valid, 1);
        check("add_res", bus.Res, 5);
        check("add_z", bus.Zflag, 0);

        send(32'h7FFFFFFF, 32'd1, 3'b000, 0);
        check("ov_res", bus.Res, 32'h80000000);
        check("ov_nvc", {bus.Nflag, bus.Vflag, bus.Cflag}, 3'b110);
        send(32'hFFFFFFFF, 32'd1, 3'b000, 0);
        check("cy_res", bus.Res, 0);
        check("cy_zcv", {bus.Zflag, bus.Cflag, bus.Vflag}, 3'b110);

        send(32'd3, 32'd5, 3'b011, 0);
        check("sub_res", bus.Res, 32'hFFFFFFFE);
        check("sub_cn", {bus.Cflag, bus.Nflag}, 2'b11);
        send(32'hFFFFFFFF, 32'd1, 3'b111, 0);
        check("slt_res", bus.Res, 1);
        send(32'hFFFFFFFF, 32'd1, 3'b110, 0);
        check("sltu_res", bus.Res, 0);
        check("sltu_z", bus.Zflag, 1);

        send(32'h0000FFFF, 32'h00010001, 3'b100, 0);
        n = 1;
        nb = 0;
        while (!bus.out_valid && n < 100) begin
            nb += int'(bus.busy);
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_lat", n, 33);
        check("mul_busy", nb, 32);
        check("mul_res", bus.Res, 32'hFFFFFFFF);
        check("mul_c", bus.Cflag, 0);
        send(32'h00010000, 32'h00010000, 3'b100, 0);
        n = 1;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mul2_res", bus.Res, 0);
        check("mul2_zc", {bus.Zflag, bus.Cflag}, 2'b11);
        send(32'hDEADBEEF, 32'h12345679, 3'b100, 0);
        drain();

        bus.out_ready = 1'b0;
        send(32'hF0F0F0F0, 32'hFFFF0000, 3'b101, 0);
        check("xor_res", bus.Res, 32'h0F0FF0F0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.A = 32'h12345678 + i;
            @(posedge clk);
            #1;
            check("stall_res", bus.Res, 32'h0F0FF0F0);
            check("stall_iready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        n = n_out;
        send(32'hCAFE0F0F, 32'h0FF00FF0, 3'b001, 1);
        a0 = acc_cyc;
        send(32'h00F000F0, 32'h12000034, 3'b010, 1);
        a1 = acc_cyc;
        send(32'h00000010, 32'h00000020, 3'b011, 1);
        a2 = acc_cyc;
        send(32'h00001234, 32'h00005678, 3'b100, 0);
        a3 = acc_cyc;
        check("b2b_gap1", a1 - a0, 2);
        check("b2b_gap2", a2 - a1, 2);
        check("b2b_gap3", a3 - a2, 2);
        drain();
        repeat (3) @(posedge clk);
        check("b2b_count", n_out - n, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's single-cycle ALU. It adds a WIDTH parameter, valid/ready flow control, a full flag set (Z/N/C/V), XOR, and both signed and unsigned set-less-than.
- Multiply is iterative (shift-add, one multiplier bit per cycle) to avoid a wide combinational multiplier.
- Sits between the register-read stage and writeback. The consumer may stall results with out_ready.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width (derived; do not override).

Ports:
- CLK      input   1      rising-edge clock
- RST_N    input   1      asynchronous active-low reset
- in_valid input   1      operands/op presented
- in_ready output  1      block can accept a new operation
- A        input   WIDTH  operand A
- B        input   WIDTH  operand B
- op       input   3      000 add, 001 and, 010 or, 011 sub, 100 mul (low WIDTH bits), 101 xor, 110 sltu, 111 slt (signed)
- out_valid output 1      Res/flags valid
- out_ready input  1      consumer accepts result
- Res      output  WIDTH  result
- Zflag    output  1      Res == 0
- Nflag    output  1      Res[WIDTH-1]
- Cflag    output  1      carry/borrow, see Behaviour
- Vflag    output  1      signed overflow
- busy     output  1      multiply in progress

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (RST_N). While RST_N=0: state=IDLE; Res=0; all flags=0; out_valid=0; busy=0; counter=0; internal operand registers=0. Reset mid-multiply abandons the operation and produces no result.
- FSM states: IDLE, MUL, DONE.
  - in_ready = (state==IDLE). Acceptance = in_valid & in_ready at a rising edge; A, B and op are captured at that edge.
  - IDLE, accept, op!=100 -> DONE. Res and flags are computed from the captured inputs and registered at the same edge. out_valid=1 from the next cycle, so latency is 1 cycle.
  - IDLE, accept, op==100 -> MUL. Captures multiplicand=A, multiplier=B, acc=0, counter=0; busy=1.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand (WIDTH-bit add; overflow bit ORed into a sticky hi_nz). Then multiplicand <<= 1, multiplier >>= 1, counter++. Every bit shifted out of the multiplicand MSB while the corresponding multiplier bit is still pending also sets hi_nz.
  - MUL exits to DONE after exactly WIDTH iterations. Res=acc; flags registered on the DONE transition; busy=0. Total latency from accept to out_valid = WIDTH+1 cycles.
  - DONE: Res/flags/out_valid held stable while out_ready=0. out_valid & out_ready at an edge -> IDLE; out_valid drops next cycle. No new accept in the same cycle as DONE->IDLE, so max throughput is 1 op per 2 cycles.
  - in_valid while not in IDLE is ignored (no capture). A/B/op changes after acceptance do not affect the in-flight result.
- Arithmetic (WIDTH-bit, wrap-around modulo 2^WIDTH):
  - add: C = carry out of bit WIDTH-1; V = (A[msb]==B[msb]) & (Res[msb]!=A[msb]).
  - sub: Res = A-B; C = borrow = (A <u B); V = (A[msb]!=B[msb]) & (Res[msb]!=A[msb]).
  - mul: Res = low WIDTH bits of the unsigned product; C = 1 iff the upper WIDTH bits of the full product are nonzero; V=0.
  - and/or/xor: C=0, V=0.
  - sltu: Res = (A <u B) ? 1 : 0. slt: Res = ($signed(A) < $signed(B)) ? 1 : 0. C=0, V=0.
  - Z and N are always derived from the registered Res.

Test Plan:
- Reset during MUL (WIDTH=32): accept mul 7*9; drop RST_N at cycle 10 -> outputs 0 immediately, state IDLE. After release, add 2+3 -> Res=5, out_valid 1 cycle after accept, Z=0.
- Add overflow/carry: add 0x7FFFFFFF+1 -> Res=0x80000000, N=1, V=1, C=0. Add 0xFFFFFFFF+1 -> Res=0, Z=1, C=1, V=0.
- Sub/compare: sub 3-5 -> Res=0xFFFFFFFE, C=1, N=1. slt A=0xFFFFFFFF, B=1 -> Res=1. sltu on the same operands -> Res=0, Z=1.
- Multiply: 0x0000FFFF*0x00010001 -> Res=0xFFFFFFFF, C=0, out_valid exactly 33 cycles after accept, busy high 32 cycles. 0x10000*0x10000 -> Res=0, Z=1, C=1.
- Backpressure: complete xor 0xF0F0F0F0^0xFFFF0000 -> Res=0x0F0FF0F0. Hold out_ready=0 for 5 cycles -> Res stable, in_ready=0. A new in_valid with changed A during the stall is ignored.
- Back-to-back: in_valid held high with out_ready=1 across and, or, sub, mul -> results appear in order, one accept per 2 cycles for non-mul ops, none lost or duplicated.
